debug_console_ctrl: RTL and testbench

- Memory-mapped debug console controller on the CPU-side bus of the hf-riscv SoC.
- Accepts character writes to the debug port at 0xf00000d0 and buffers them in a FIFO.
- Serialises characters onto a UART TX line, inserting a hard line feed after LINE_MAX characters without one.
- Stalls the CPU only when the FIFO is full; no character is ever dropped.

---
 rtl/debug_console_pkg.sv | 25 ++
 rtl/debug_console_fifo.sv | 78 +++++++
 rtl/debug_console_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_debug_console_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_console_pkg.sv
// Shared types and constants for the debug console controller.
package debug_console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Bit positions inside the status word.
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_ACTIVE    = 2;
    localparam int ST_COUNT_LSB = 8;

    localparam logic [7:0] LF = 8'h0A;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'hf00000d0;
    localparam logic [31:0] DEF_STAT_ADDR  = 32'hf00000d4;
    localparam int          DEF_FIFO_DEPTH = 16;
    localparam int          DEF_CLK_DIV    = 217;
    localparam int          DEF_LINE_MAX   = 72;

endpackage

// File: rtl/debug_console_fifo.sv
// Synchronous FIFO with registered occupancy count. Push is ignored when
// full and pop is ignored when empty; the head is the oldest entry.
module debug_console_fifo
    import debug_console_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Flags come straight from the registered count.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        head    = mem_q[rd_ptr_q];
        push_ok = push && !full;
        pop_ok  = pop && !empty;
    end

    // Pointer, count and storage update; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/debug_console_ctrl.sv
// Memory-mapped debug console: CPU character writes are queued in a FIFO and
// serialised 8N1 on uart_tx, with a line feed inserted after LINE_MAX
// characters on one line. The CPU is stalled only while the FIFO is full.
module debug_console_ctrl
    import debug_console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR,
    parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int          CLK_DIV    = DEF_CLK_DIV,
    parameter int          LINE_MAX   = DEF_LINE_MAX
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_write,
    input  logic [3:0]  data_we,
    output logic [31:0] data_read,
    output logic        stall,
    output logic        uart_tx,
    output logic        busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int COL_W = $clog2(LINE_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(LINE_MAX);

    logic             write_hit;
    logic             read_hit;
    logic             push;
    logic             pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    tx_state_t        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             tx_q, tx_d;
    logic [31:0]      data_read_q, data_read_d;

    logic             bit_end;
    logic             take;
    logic [7:0]       sel_byte;
    logic             sel_pop;
    logic [COL_W-1:0] sel_col;

    // Only the top byte of the write data carries the character.
    logic unused_low_bits;
    assign unused_low_bits = ^data_write[23:0];

    debug_console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock_in),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data_write[31:24]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus decode: a write to a full FIFO stalls in the same cycle; the held
    // write is accepted on the first cycle the registered count is not full.
    always_comb begin
        write_hit = (address == BASE_ADDR) && (data_we != 4'b0000);
        read_hit  = (address == STAT_ADDR) && (data_we == 4'b0000);
        stall     = write_hit && fifo_full;
        push      = write_hit && !fifo_full;
    end

    // Next-byte selection with line wrapping; the LF is inserted without
    // popping so the waiting head goes out in the following frame.
    always_comb begin
        sel_byte = fifo_head;
        sel_pop  = 1'b1;
        sel_col  = col_q + 1'b1;
        if (fifo_head == LF) begin
            sel_byte = LF;
            sel_col  = '0;
        end else if (col_q == COL_MAX) begin
            sel_byte = LF;
            sel_pop  = 1'b0;
            sel_col  = '0;
        end
    end

    // TX FSM next state; STOP chains straight into START when data waits.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        col_d   = col_q;
        pop     = 1'b0;
        take    = 1'b0;
        bit_end = (div_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                div_d = '0;
                take  = !fifo_empty;
            end
            START: begin
                div_d = div_q + 1'b1;
                if (bit_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                div_d = div_q + 1'b1;
                if (bit_end) begin
                    div_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                div_d = div_q + 1'b1;
                if (bit_end) begin
                    div_d   = '0;
                    take    = !fifo_empty;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take) begin
            state_d = START;
            shift_d = sel_byte;
            pop     = sel_pop;
            col_d   = sel_col;
            div_d   = '0;
        end
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Status word captured for a one-cycle read latency.
    always_comb begin
        data_read_d = '0;
        if (read_hit) begin
            data_read_d[ST_FULL]                = fifo_full;
            data_read_d[ST_EMPTY]               = fifo_empty;
            data_read_d[ST_ACTIVE]              = (state_q != IDLE);
            data_read_d[ST_COUNT_LSB +: 8]      = 8'(fifo_count);
        end
    end

    // Registers; reset aborts any frame and forces the line idle high.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            col_q       <= '0;
            tx_q        <= 1'b1;
            data_read_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            col_q       <= col_d;
            tx_q        <= tx_d;
            data_read_q <= data_read_d;
        end
    end

    assign uart_tx   = tx_q;
    assign data_read = data_read_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_debug_console_ctrl.sv
// Bench for debug_console_ctrl: bus driver tasks, a UART line monitor that
// decodes frames into rx_q, and a stream-level line-wrap model filling exp_q.
module tb_debug_console_ctrl;

    localparam int CD    = 4;
    localparam int DEPTH = 16;
    localparam int LMAX  = 72;
    localparam logic [31:0] BASE = 32'hf00000d0;
    localparam logic [31:0] STAT = 32'hf00000d4;

    logic        clock_in = 1'b0;
    logic        reset    = 1'b0;
    logic [31:0] address;
    logic [31:0] data_write;
    logic [3:0]  data_we;
    logic [31:0] data_read;
    logic        stall;
    logic        uart_tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int model_col = 0;
    int mon_bad_stop = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] mon_b;

    debug_console_ctrl #(
        .BASE_ADDR  (BASE),
        .STAT_ADDR  (STAT),
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (CD),
        .LINE_MAX   (LMAX)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .address    (address),
        .data_write (data_write),
        .data_we    (data_we),
        .data_read  (data_read),
        .stall      (stall),
        .uart_tx    (uart_tx),
        .busy       (busy)
    );

    // Clock and watchdog.
    always #5 clock_in = ~clock_in;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // UART monitor: sample each cell in its middle, push decoded bytes.
    always begin
        @(negedge clock_in);
        if (reset === 1'b1 && uart_tx === 1'b0) begin
            repeat (CD / 2) @(negedge clock_in);
            for (int i = 0; i < 8; i++) begin
                repeat (CD) @(negedge clock_in);
                mon_b[i] = uart_tx;
            end
            repeat (CD) @(negedge clock_in);
            if (uart_tx !== 1'b1) mon_bad_stop++;
            rx_q.push_back(mon_b);
            repeat (CD - CD / 2 - 1) @(negedge clock_in);
        end
    end

    // Reference model: expected serial stream from the written characters.
    function automatic void model_push(input logic [7:0] b);
        if (b == 8'h0A) begin
            exp_q.push_back(b);
            model_col = 0;
        end else begin
            if (model_col == LMAX) begin
                exp_q.push_back(8'h0A);
                model_col = 0;
            end
            exp_q.push_back(b);
            model_col++;
        end
    endfunction

    task automatic bus_idle();
        address    = 32'h0;
        data_write = 32'h0;
        data_we    = 4'h0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic bus_write(input logic [31:0] a, input logic [7:0] b, output int stalls);
        address    = a;
        data_write = {b, 24'($urandom)};
        data_we    = 4'($urandom_range(1, 15));
        stalls     = 0;
        #1;
        while (stall === 1'b1 && stalls < 2000) begin
            @(negedge clock_in);
            #1;
            stalls++;
        end
        checks++;
        if (stalls >= 2000) begin
            errors++;
            $display("FAIL write_timeout: stalled %0d cycles, limit 2000", stalls);
        end
        @(posedge clock_in);
        @(negedge clock_in);
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
        address    = a;
        data_we    = 4'h0;
        data_write = $urandom;
        @(posedge clock_in);
        @(negedge clock_in);
        rd = data_read;
        bus_idle();
    endtask

    task automatic wait_idle(output bit timed_out);
        int n = 0;
        while (busy === 1'b1 && n < 20000) begin
            @(negedge clock_in);
            n++;
        end
        timed_out = (busy !== 1'b0);
        repeat (2) @(negedge clock_in);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset   = 1'b0;
        address = STAT;
        repeat (3) @(negedge clock_in);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++;
        if (data_read !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", data_read); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        bus_idle();
        @(negedge clock_in);
        bus_read(STAT, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", rd); end
        model_col = 0;
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_single_frame();
        int st;
        bit to;
        logic [7:0] ch = 8'h41;
        logic exp_bit;
        model_push(ch);
        bus_write(BASE, ch, st);
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL frame_pre: tx=%b busy=%b expected tx=1 busy=1", uart_tx, busy);
        end
        for (int c = 0; c < 10 * CD; c++) begin
            @(negedge clock_in);
            if (c < CD) exp_bit = 1'b0;
            else if (c < 9 * CD) exp_bit = ch[(c - CD) / CD];
            else exp_bit = 1'b1;
            checks++;
            if (uart_tx !== exp_bit || busy !== 1'b1) begin
                errors++;
                $display("FAIL frame_cycle[%0d]: tx=%b busy=%b expected tx=%b busy=1", c, uart_tx, busy, exp_bit);
            end
        end
        @(negedge clock_in);
        checks++;
        if (busy !== 1'b0 || uart_tx !== 1'b1) begin
            errors++; $display("FAIL frame_end: busy=%b tx=%b expected busy=0 tx=1", busy, uart_tx);
        end
        wait_idle(to);
        checks++;
        if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL frame_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int st;
        bit to;
        logic [7:0] b;
        for (int i = 0; i <= DEPTH + 1; i++) begin
            b = 8'($urandom_range(33, 126));
            model_push(b);
            bus_write(BASE, b, st);
            checks++;
            if (i <= DEPTH) begin
                if (st !== 0) begin errors++; $display("FAIL b2b_nostall[%0d]: stalled %0d expected 0", i, st); end
            end else begin
                // The first frame pops one cycle after the first push; the
                // second pop comes one frame later.
                if (st !== 10 * CD + 2 - (DEPTH + 1)) begin
                    errors++; $display("FAIL b2b_stall: stalled %0d expected %0d", st, 10 * CD + 2 - (DEPTH + 1));
                end
            end
        end
        wait_idle(to);
        checks++;
        if (to) begin errors++; $display("FAIL b2b_drain: busy=%b expected 0", busy); end
        checks++;
        if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_status();
        int st;
        bit to;
        logic [7:0] b;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int n = 4;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(33, 126));
            model_push(b);
            bus_write(BASE, b, st);
        end
        // One byte is already in flight, the rest wait in the FIFO.
        exp_rd = (32'(n - 1) << 8) | 32'h4;
        bus_read(STAT, rd);
        checks++;
        if (rd !== exp_rd) begin errors++; $display("FAIL status_active: got %h expected %h", rd, exp_rd); end
        @(negedge clock_in);
        checks++;
        if (data_read !== 32'h0) begin errors++; $display("FAIL status_clear: got %h expected 0", data_read); end
        wait_idle(to);
        bus_read(STAT, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL status_idle: got %h expected 00000002", rd); end
        checks++;
        if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL status_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL status_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_bad_addr();
        int st;
        logic [31:0] rd;
        bus_write(32'hf00000d8, 8'h51, st);
        checks++;
        if (st !== 0) begin errors++; $display("FAIL bad_write_stall: stalled %0d expected 0", st); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bad_write_busy: got %b expected 0", busy); end
        bus_read(BASE, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL bad_read_data: got %h expected 0", rd); end
        bus_read(32'hf00000d8, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL bad_read_other: got %h expected 0", rd); end
        repeat (10) @(negedge clock_in);
        checks++;
        if (busy !== 1'b0 || uart_tx !== 1'b1 || rx_q.size() != 0) begin
            errors++; $display("FAIL bad_quiet: busy=%b tx=%b frames=%0d expected 0 1 0", busy, uart_tx, rx_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int st;
        bit to;
        logic [31:0] rd;
        bus_write(BASE, 8'h55, st);
        repeat (15) @(negedge clock_in);
        reset = 1'b0;
        @(negedge clock_in);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b expected 1", uart_tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        reset = 1'b1;
        bus_read(STAT, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL rst_mid_status: got %h expected 00000002", rd); end
        model_col = 0;
        repeat (60) @(negedge clock_in);
        rx_q.delete();
        exp_q.delete();
        model_push(8'h78);
        bus_write(BASE, 8'h78, st);
        wait_idle(to);
        checks++;
        if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rst_clean_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_clean_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Continues the line started after the mid-frame reset: 1 + 72 'x'.
    task automatic test_line_wrap();
        int st;
        bit to;
        int lf_seen = 0;
        for (int i = 0; i < LMAX; i++) begin
            model_push(8'h78);
            bus_write(BASE, 8'h78, st);
        end
        wait_idle(to);
        checks++;
        if (rx_q.size() < LMAX || rx_q[LMAX - 1] !== 8'h0A) begin
            errors++; $display("FAIL wrap_lf_pos: %0d bytes received, LF expected at index %0d", rx_q.size(), LMAX - 1);
        end
        checks++;
        if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete();
        exp_q.delete();
        // Column is 1 here: 9 'x', an explicit LF, then a full line.
        for (int i = 0; i < 9 + 1 + LMAX; i++) begin
            logic [7:0] b;
            b = (i == 9) ? 8'h0A : 8'h78;
            model_push(b);
            bus_write(BASE, b, st);
        end
        wait_idle(to);
        foreach (rx_q[i]) if (rx_q[i] == 8'h0A) lf_seen++;
        checks++;
        if (lf_seen != 1) begin errors++; $display("FAIL wrap_explicit_lf: got %0d LFs expected 1", lf_seen); end
        checks++;
        if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap2_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap2_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int st;
        bit to;
        logic [7:0] b;
        for (int i = 0; i < 80; i++) begin
            b = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom);
            model_push(b);
            bus_write(BASE, b, st);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(20, 60)) @(negedge clock_in);
            else repeat ($urandom_range(0, 3)) @(negedge clock_in);
        end
        wait_idle(to);
        checks++;
        if (to) begin errors++; $display("FAIL rand_drain: busy=%b expected 0", busy); end
        checks++;
        if (mon_bad_stop != 0) begin errors++; $display("FAIL rand_stop_bits: got %0d bad stop bits expected 0", mon_bad_stop); end
        checks++;
        if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_status();
        test_bad_addr();
        test_reset_mid_frame();
        test_line_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
